// File: rtl/otf_pkg.sv
// otf_pkg: shared state encoding, digit helpers and parameter limits
// for the on-the-fly quotient converter.
package otf_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} otf_state_t;
   localparam int RADIX_LOG2_MIN = 1;
   localparam int RADIX_LOG2_MAX = 3;
   localparam int DIGIT_W_MAX = 8;
   function automatic int otf_out_w(input int radix_log2, input int ndigits);
      return radix_log2 * ndigits;
   endfunction
   function automatic logic [DIGIT_W_MAX-1:0] digit_abs(input logic signed [DIGIT_W_MAX-1:0] d);
      return d[DIGIT_W_MAX-1] ? -d : d;
   endfunction
   function automatic bit otf_params_ok(input int radix_log2, input int maxdigit, input int digit_w,
                                        input int ndigits, input int out_w);
      return radix_log2 >= RADIX_LOG2_MIN && radix_log2 <= RADIX_LOG2_MAX &&
             maxdigit >= 1 && maxdigit <= (1 << radix_log2) - 1 &&
             digit_w >= 2 && digit_w <= DIGIT_W_MAX && ndigits >= 2 &&
             out_w == otf_out_w(radix_log2, ndigits);
   endfunction
endpackage

// File: rtl/otf_append.sv
// otf_append: next Q / QM values after appending one signed radix-2^k digit.
module otf_append
   import otf_pkg::*;
#(
   parameter int RADIX_LOG2 = 2,
   parameter int DIGIT_W = 3,
   parameter int OUT_W = 24
) (
   input  logic signed [DIGIT_W-1:0] q,
   input  logic [OUT_W-1:0]          q_reg,
   input  logic [OUT_W-1:0]          qm_reg,
   output logic [OUT_W-1:0]          q_new,
   output logic [OUT_W-1:0]          qm_new
);
   localparam logic [OUT_W-1:0] RMAX = OUT_W'((1 << RADIX_LOG2) - 1);
   localparam logic [OUT_W-1:0] ONE = OUT_W'(1);
   logic neg, pos;
   logic [OUT_W-1:0] mag, q_ext, lo_q, lo_qm;
   // Negative digits borrow from QM; only strictly positive digits let QM borrow from Q.
   always_comb begin
      neg = q[DIGIT_W-1];
      pos = !neg && (q != '0);
      mag = OUT_W'(digit_abs(DIGIT_W_MAX'(q)));
      q_ext = OUT_W'(q);
      lo_q = neg ? RMAX + ONE - mag : q_ext;
      lo_qm = pos ? q_ext - ONE : RMAX - mag;
      q_new = ((neg ? qm_reg : q_reg) << RADIX_LOG2) | (lo_q & RMAX);
      qm_new = ((pos ? q_reg : qm_reg) << RADIX_LOG2) | (lo_qm & RMAX);
   end
endmodule

// File: rtl/onthefly_conv_param.sv
// onthefly_conv_param: MSD-first on-the-fly conversion of signed redundant
// quotient digits into two's complement, with start/done handshake.
module onthefly_conv_param
   import otf_pkg::*;
#(
   parameter int RADIX_LOG2 = 2,
   parameter int MAXDIGIT = 2,
   parameter int DIGIT_W = 3,
   parameter int NDIGITS = 12,
   parameter int OUT_W = otf_out_w(RADIX_LOG2, NDIGITS)
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic                      CE,
   input  logic                      start,
   input  logic                      din_valid,
   input  logic signed [DIGIT_W-1:0] q,
   input  logic                      rem_neg,
   output logic                      busy,
   output logic                      done,
   output logic                      dig_err,
   output logic [OUT_W-1:0]          q_res,
   output logic [OUT_W-1:0]          qm_res
);
   localparam int CNT_W = $clog2(NDIGITS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIGITS - 1);
   localparam logic [DIGIT_W_MAX-1:0] MAXD = DIGIT_W_MAX'(MAXDIGIT);

   generate
      if (!otf_params_ok(RADIX_LOG2, MAXDIGIT, DIGIT_W, NDIGITS, OUT_W)) begin : g_bad_params
         $error("onthefly_conv_param: illegal parameter combination");
      end
   endgenerate

   otf_state_t st, st_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [OUT_W-1:0] q_r, qm_r, q_n, qm_n, q_app, qm_app, q_res_n, qm_res_n;
   logic done_n, dig_err_n, legal;

   otf_append #(
      .RADIX_LOG2(RADIX_LOG2),
      .DIGIT_W(DIGIT_W),
      .OUT_W(OUT_W)
   ) u_append (
      .q(q),
      .q_reg(q_r),
      .qm_reg(qm_r),
      .q_new(q_app),
      .qm_new(qm_app)
   );

   assign busy = (st == CONV);

   always_comb begin
      st_n = st;
      cnt_n = cnt;
      q_n = q_r;
      qm_n = qm_r;
      q_res_n = q_res;
      qm_res_n = qm_res;
      done_n = 1'b0;
      dig_err_n = 1'b0;
      legal = digit_abs(DIGIT_W_MAX'(q)) <= MAXD;
      // start wins over any digit presented in the same cycle
      if (start) begin
         st_n = CONV;
         cnt_n = '0;
         q_n = '0;
         qm_n = '1;
      end else if (st == CONV && din_valid) begin
         if (!legal) begin
            dig_err_n = 1'b1;
         end else begin
            q_n = q_app;
            qm_n = qm_app;
            cnt_n = cnt + CNT_W'(1);
            if (cnt == LAST) begin
               st_n = DONE;
               q_res_n = rem_neg ? qm_app : q_app;
               qm_res_n = qm_app;
               done_n = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) st <= IDLE;
      else if (CE) st <= st_n;
   end

   // QM resets to all-ones so a negative first digit sign-extends correctly
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt <= '0;
         q_r <= '0;
         qm_r <= '1;
         q_res <= '0;
         qm_res <= '0;
         done <= 1'b0;
         dig_err <= 1'b0;
      end else if (CE) begin
         cnt <= cnt_n;
         q_r <= q_n;
         qm_r <= qm_n;
         q_res <= q_res_n;
         qm_res <= qm_res_n;
         done <= done_n;
         dig_err <= dig_err_n;
      end
   end
endmodule

// File: doc/onthefly_conv_param.md
Name: onthefly_conv_param

Overview:
- Parametrised on-the-fly converter for the digit-recurrence divider and square-root datapath.
- Accepts one signed redundant quotient digit per cycle, MSD first, and keeps the two-register pair Q / QM (QM = Q − 1 ulp).
- Digits are appended by shift with an internal digit counter; no external pointer.
- Adds a start/done handshake, out-of-range digit detection and final remainder-sign correction. Sits between the SRT digit-selection stage and the result register.

Parameters:
- RADIX_LOG2, 2, log2 of radix (1, 2 or 3: radix 2/4/8)
- MAXDIGIT, 2, largest allowed |digit| in the redundant set; must satisfy MAXDIGIT ≤ 2^RADIX_LOG2 − 1
- DIGIT_W, 3, width of the signed two's-complement digit input
- NDIGITS, 12, digits per conversion
- OUT_W, NDIGITS*RADIX_LOG2, result width (derived; do not override)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- CE  in  1  clock enable; low freezes all state and outputs
- start  in  1  begin a new conversion (clears Q/QM and the counter)
- din_valid  in  1  digit qualifier
- q  in  DIGIT_W  signed quotient digit
- rem_neg  in  1  final partial remainder negative; sampled with the NDIGITS-th digit
- busy  out  1  conversion in progress
- done  out  1  single-cycle pulse: result valid
- dig_err  out  1  single-cycle pulse: rejected digit (|q| > MAXDIGIT)
- q_res  out  OUT_W  corrected result, two's complement
- qm_res  out  OUT_W  uncorrected Q − 1 ulp, for the rounding stage

Behaviour:
- Reset (nRST low, asynchronous):
  - State returns to IDLE.
  - Q, q_res and qm_res clear to 0; QM sets to all-ones.
  - cnt clears to 0; busy, done and dig_err go low.
- All state updates require CE=1. With CE=0, every register, including any asserted done or dig_err pulse, holds.
- FSM states: IDLE, CONV, DONE.
  - IDLE/DONE + start → CONV. Load Q=0, QM=all-ones, cnt=0.
  - CONV + start → restart CONV with the same clear (abort). The digit presented in that cycle is ignored.
  - CONV + din_valid + legal digit:
    - Update Q/QM and increment cnt.
    - When cnt reaches NDIGITS: go to DONE, select q_res = rem_neg ? QM_new : Q_new, set qm_res = QM_new, and pulse done for exactly one cycle.
  - CONV + din_valid + |q| > MAXDIGIT: pulse dig_err. Q, QM and cnt stay unchanged.
  - din_valid in IDLE or DONE is ignored. No dig_err is raised.
  - DONE holds q_res/qm_res until the next start; busy stays low.
- busy = 1 exactly while in CONV.
- Update rules, with r = 2^RADIX_LOG2 and k = RADIX_LOG2, all arithmetic truncated to OUT_W:
  - Q_new = (q ≥ 0) ? {Q, q} : {QM, r − |q|}
  - QM_new = (q > 0) ? {Q, q − 1} : {QM, r − 1 − |q|}
  - {X, v} means (X << k) | v[k−1:0].
- Invariant: after every accepted digit, QM = Q − 1 mod 2^OUT_W. q_res equals the Horner value of the digits mod 2^OUT_W, minus 1 when rem_neg = 1.
- Latency: q_res and done are valid on the clock edge that accepts the last digit.
- A gap cycle (din_valid = 0) in CONV holds all state.
- A negative first digit must give a correctly sign-extended negative result; the all-ones QM initial value guarantees this.

Decomposition:
- Shared package otf_pkg:
  - state encoding (IDLE/CONV/DONE)
  - function digit_abs
  - function for derived OUT_W
  - legal-parameter check constants
- One natural sub-module, otf_append: combinational Q_new/QM_new generator for one digit. The parent holds the FSM, counter and registers.

Test Plan:
1. RADIX_LOG2=2, NDIGITS=4, no rem_neg: start, digits 1, 2, −2, 0 → done on the 4th accept edge; q_res=0x58, qm_res=0x57.
2. Same configuration, digits −1, 0, 0, 0 → q_res=0xC0 (−64). Digits 0, 2, −2, 0 with rem_neg=1 on the last digit → q_res=0x17, qm_res=0x17.
3. NDIGITS=12, OUT_W=24, digit sequence 0, 2, −2, 0, 1, −2, 2, −1, −1, −2, 1, 0 with a 2-cycle din_valid gap after the 5th digit → q_res=0x1826A4, done on the 12th accept; no dig_err.
4. Digit 3 mid-conversion (MAXDIGIT=2) → dig_err pulses once. Q, QM and cnt are unchanged; the following legal digits give the same result as test 1.
5. CE low for 3 cycles while done is high → done stays high; q_res is stable. start during CONV → busy stays 1, result reflects only post-restart digits. nRST pulse mid-conversion → q_res=0, busy=0, done=0 immediately, without waiting for CLK.
6. RADIX_LOG2=1, MAXDIGIT=1, NDIGITS=8, digits 1, −1, 0, 1, 0, 0, −1, 1 → q_res=0x4F (Horner value 79).
